// File: rtl/led_frame_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_frame_scheduler_if
// Brief    : Pixel fetch bus between the upstream pixel source and the scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface led_frame_scheduler_if;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [15:0] pixel_index;

    modport master (
        output pixel_data,
        output pixel_valid,
        input  pixel_ready,
        input  pixel_index
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready,
        output pixel_index
    );
endinterface
`default_nettype wire

// File: rtl/led_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_frame_scheduler
// Brief    : Fetches NUM_LEDS pixels per frame tick and sends them as WS2812-style
//            NRZ pulses. Optional macro LED_FRAME_OVERRUN_COUNT_EN adds a
//            saturating count of start edges dropped while busy.
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_scheduler #(
    parameter int NUM_LEDS     = 60,
    parameter int BIT_CYCLES   = 15,
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 8,
    parameter int LATCH_CYCLES = 960
) (
    input  wire logic                 clock_12mhz,
    input  wire logic                 reset,
    input  wire logic                 frame_tick,
    led_frame_scheduler_if.slave      pix,
    output logic                      led_out,
    output logic                      busy,
    output logic                      frame_done
`ifdef LED_FRAME_OVERRUN_COUNT_EN
    ,
    input  wire logic                 overrun_clear,
    output logic [7:0]                overrun_count
`endif
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [CYC_W-1:0] C_CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] C_T0H      = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] C_T1H      = CYC_W'(T1H_CYCLES);
    localparam logic [LAT_W-1:0] C_LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [15:0]      C_PIX_LAST = 16'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t            r_state,       w_state_nxt;
    logic              r_tick_d;
    logic [23:0]       r_shift,       w_shift_nxt;
    logic [4:0]        r_bit_cnt,     w_bit_cnt_nxt;
    logic [CYC_W-1:0]  r_cyc_cnt,     w_cyc_cnt_nxt;
    logic [LAT_W-1:0]  r_lat_cnt,     w_lat_cnt_nxt;
    logic [15:0]       r_pixel_index, w_pixel_index_nxt;
    logic              r_led_out,     w_led_out_nxt;
    logic              r_frame_done,  w_frame_done_nxt;
    logic              w_start;

    assign w_start         = frame_tick & ~r_tick_d;
    assign pix.pixel_ready = (r_state == S_FETCH);
    assign pix.pixel_index = r_pixel_index;
    assign led_out         = r_led_out;
    assign busy            = (r_state != S_IDLE);
    assign frame_done      = r_frame_done;

    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tick_d      <= 1'b1;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_cyc_cnt     <= '0;
            r_lat_cnt     <= '0;
            r_pixel_index <= '0;
            r_led_out     <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tick_d      <= frame_tick;
            r_shift       <= w_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_cyc_cnt     <= w_cyc_cnt_nxt;
            r_lat_cnt     <= w_lat_cnt_nxt;
            r_pixel_index <= w_pixel_index_nxt;
            r_led_out     <= w_led_out_nxt;
            r_frame_done  <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_shift_nxt       = r_shift;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_cyc_cnt_nxt     = r_cyc_cnt;
        w_lat_cnt_nxt     = r_lat_cnt;
        w_pixel_index_nxt = r_pixel_index;
        w_frame_done_nxt  = 1'b0;
        w_led_out_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt       = S_FETCH;
                    w_pixel_index_nxt = '0;
                end
            end
            S_FETCH: begin
                if (pix.pixel_valid) begin
                    w_shift_nxt   = pix.pixel_data;
                    w_bit_cnt_nxt = 5'd23;
                    w_cyc_cnt_nxt = '0;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                if (r_cyc_cnt == C_CYC_LAST) begin
                    w_cyc_cnt_nxt = '0;
                    if (r_bit_cnt == 5'd0) begin
                        if (r_pixel_index == C_PIX_LAST) begin
                            w_state_nxt   = S_LATCH;
                            w_lat_cnt_nxt = '0;
                        end else begin
                            w_pixel_index_nxt = r_pixel_index + 16'd1;
                            w_state_nxt       = S_FETCH;
                        end
                    end else begin
                        w_shift_nxt   = {r_shift[22:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - 5'd1;
                    end
                end else begin
                    w_cyc_cnt_nxt = r_cyc_cnt + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_lat_cnt == C_LAT_LAST) begin
                    w_frame_done_nxt  = 1'b1;
                    w_pixel_index_nxt = '0;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Pulse level is derived from next-cycle counters so the first high
        // sample appears in the cycle right after the pixel is accepted.
        if (w_state_nxt == S_SEND)
            w_led_out_nxt = (w_cyc_cnt_nxt < (w_shift_nxt[23] ? C_T1H : C_T0H));
    end

`ifdef LED_FRAME_OVERRUN_COUNT_EN
    logic [7:0] r_overrun_count;

    assign overrun_count = r_overrun_count;

    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset)
            r_overrun_count <= 8'd0;
        else if (overrun_clear)
            r_overrun_count <= 8'd0;
        else if (w_start && (r_state != S_IDLE) && (r_overrun_count != 8'hFF))
            r_overrun_count <= r_overrun_count + 8'd1;
    end
`endif

endmodule
`default_nettype wire
